// File: rtl/wb_reorder_buffer_pkg.sv
// Shared definitions for the writeback reorder buffer: slot states, sizing
// and the bit layout of a stored result word {info, id, so, data}.
package wb_reorder_buffer_pkg;

  localparam int INFO_LENGTH_DEF = 20;
  localparam int ORDER_ID_DEF    = 3;
  localparam int DATA_LENGTH_DEF = 512;
  localparam int TAG_WIDTH_DEF   = 3;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  function automatic int rob_depth(input int tag_width);
    return 1 << tag_width;
  endfunction

  function automatic int rob_word_width(input int info_length, input int order_id,
                                        input int data_length);
    return info_length + order_id + 1 + data_length;
  endfunction

  // Payload occupies the LSBs, so sits directly above it, then id, then info.
  function automatic int rob_so_pos(input int data_length);
    return data_length;
  endfunction

  function automatic int rob_id_lsb(input int data_length);
    return data_length + 1;
  endfunction

  function automatic int rob_info_lsb(input int order_id, input int data_length);
    return data_length + 1 + order_id;
  endfunction

endpackage

// File: rtl/wb_reorder_buffer_if.sv
// Bundle of the allocation, lookup-result and writeback signals of the ROB.
interface wb_reorder_buffer_if
  import wb_reorder_buffer_pkg::*;
#(
  parameter int info_length = INFO_LENGTH_DEF,
  parameter int order_id    = ORDER_ID_DEF,
  parameter int data_length = DATA_LENGTH_DEF,
  parameter int tag_width   = TAG_WIDTH_DEF
);
  logic                   alloc_req;
  logic                   alloc_gnt;
  logic [tag_width-1:0]   alloc_tag;

  logic                   lkp_vld;
  logic [tag_width-1:0]   lkp_tag;
  logic [info_length-1:0] lkp_info;
  logic [order_id-1:0]    lkp_id;
  logic                   lkp_so;
  logic [data_length-1:0] lkp_data;

  logic                   output_busy_0;
  logic                   reg0_wb_valid;
  logic [info_length-1:0] reg0_wb_info;
  logic [order_id-1:0]    reg0_wb_id;
  logic                   reg0_wb_so;
  logic [data_length-1:0] reg_data_o;

  logic [tag_width:0]     rob_cnt;
  logic                   err_tag;

  modport slave (
    input  alloc_req, lkp_vld, lkp_tag, lkp_info, lkp_id, lkp_so, lkp_data, output_busy_0,
    output alloc_gnt, alloc_tag, reg0_wb_valid, reg0_wb_info, reg0_wb_id, reg0_wb_so,
           reg_data_o, rob_cnt, err_tag
  );

  modport master (
    output alloc_req, lkp_vld, lkp_tag, lkp_info, lkp_id, lkp_so, lkp_data, output_busy_0,
    input  alloc_gnt, alloc_tag, reg0_wb_valid, reg0_wb_info, reg0_wb_id, reg0_wb_so,
           reg_data_o, rob_cnt, err_tag
  );

endinterface

// File: rtl/wb_rob_mem.sv
// Result storage: one synchronous write port, one combinational read port
// addressed by the head index. Contents are not reset.
module wb_rob_mem
  import wb_reorder_buffer_pkg::*;
#(
  parameter int addr_width = TAG_WIDTH_DEF,
  parameter int depth      = rob_depth(addr_width),
  parameter int word_width = rob_word_width(INFO_LENGTH_DEF, ORDER_ID_DEF, DATA_LENGTH_DEF)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [word_width-1:0] wr_word,
  input  logic [addr_width-1:0] rd_addr,
  output logic [word_width-1:0] rd_word
);

  logic [word_width-1:0] mem_reg [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem_reg[rd_addr];

endmodule

// File: rtl/wb_reorder_buffer.sv
// Writeback reorder buffer: hands out tags in arrival order, captures
// out-of-order results and pushes them to the output FIFO in tag order.
module wb_reorder_buffer
  import wb_reorder_buffer_pkg::*;
#(
  parameter int info_length = INFO_LENGTH_DEF,
  parameter int order_id    = ORDER_ID_DEF,
  parameter int data_length = DATA_LENGTH_DEF,
  parameter int tag_width   = TAG_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  wb_reorder_buffer_if.slave bus
);

  localparam int DEPTH    = rob_depth(tag_width);
  localparam int PTR_W    = tag_width + 1;
  localparam int WORD_W   = rob_word_width(info_length, order_id, data_length);
  localparam int SO_POS   = rob_so_pos(data_length);
  localparam int ID_LSB   = rob_id_lsb(data_length);
  localparam int INFO_LSB = rob_info_lsb(order_id, data_length);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0]     alloc_ptr_reg, alloc_ptr_next;
  logic [PTR_W-1:0]     head_ptr_reg, head_ptr_next;
  logic [PTR_W-1:0]     rob_cnt;
  logic [tag_width-1:0] alloc_idx, head_idx;
  slot_state_e          slot_state_reg  [DEPTH];
  slot_state_e          slot_state_next [DEPTH];
  logic                 err_tag_reg, err_tag_next;

  logic                 alloc_fire, capture_fire, bad_result, retire_fire;
  logic [DEPTH-1:0]     alloc_hit, capture_hit, retire_hit;
  logic [WORD_W-1:0]    wr_word, head_word;

  assign alloc_idx = alloc_ptr_reg[tag_width-1:0];
  assign head_idx  = head_ptr_reg[tag_width-1:0];
  assign rob_cnt   = alloc_ptr_reg - head_ptr_reg;

  // Reset gates the grant directly so alloc_gnt drops without waiting for an edge.
  assign alloc_fire   = rst && bus.alloc_req && (rob_cnt < DEPTH_CNT);
  assign capture_fire = bus.lkp_vld && (slot_state_reg[bus.lkp_tag] == SLOT_PEND);
  assign bad_result   = bus.lkp_vld && (slot_state_reg[bus.lkp_tag] != SLOT_PEND);
  assign retire_fire  = (slot_state_reg[head_idx] == SLOT_DONE) && !bus.output_busy_0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_hit
      assign alloc_hit[gi]   = alloc_fire   && (alloc_idx   == tag_width'(gi));
      assign capture_hit[gi] = capture_fire && (bus.lkp_tag == tag_width'(gi));
      assign retire_hit[gi]  = retire_fire  && (head_idx    == tag_width'(gi));
    end
  endgenerate

  // The three events can only ever target distinct slots: allocation hits a
  // FREE slot, capture a PEND slot and retire a DONE slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_state_next[i] = slot_state_reg[i];
      if (alloc_hit[i]) begin
        slot_state_next[i] = SLOT_PEND;
      end else if (capture_hit[i]) begin
        slot_state_next[i] = SLOT_DONE;
      end else if (retire_hit[i]) begin
        slot_state_next[i] = SLOT_FREE;
      end
    end
    alloc_ptr_next = alloc_ptr_reg;
    head_ptr_next  = head_ptr_reg;
    err_tag_next   = err_tag_reg;
    if (alloc_fire) begin
      alloc_ptr_next = alloc_ptr_reg + PTR_ONE;
    end
    if (retire_fire) begin
      head_ptr_next = head_ptr_reg + PTR_ONE;
    end
    if (bad_result) begin
      err_tag_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_state_reg[i] <= SLOT_FREE;
      end
      alloc_ptr_reg <= '0;
      head_ptr_reg  <= '0;
      err_tag_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_state_reg[i] <= slot_state_next[i];
      end
      alloc_ptr_reg <= alloc_ptr_next;
      head_ptr_reg  <= head_ptr_next;
      err_tag_reg   <= err_tag_next;
    end
  end

  assign wr_word = {bus.lkp_info, bus.lkp_id, bus.lkp_so, bus.lkp_data};

  wb_rob_mem #(
    .addr_width (tag_width),
    .depth      (DEPTH),
    .word_width (WORD_W)
  ) u_mem (
    .clk     (clk),
    .we      (capture_fire),
    .wr_addr (bus.lkp_tag),
    .wr_word (wr_word),
    .rd_addr (head_idx),
    .rd_word (head_word)
  );

  assign bus.alloc_gnt     = alloc_fire;
  assign bus.alloc_tag     = alloc_idx;
  assign bus.reg0_wb_valid = retire_fire;
  assign bus.reg0_wb_info  = head_word[INFO_LSB +: info_length];
  assign bus.reg0_wb_id    = head_word[ID_LSB +: order_id];
  assign bus.reg0_wb_so    = head_word[SO_POS];
  assign bus.reg_data_o    = head_word[data_length-1:0];
  assign bus.rob_cnt       = rob_cnt;
  assign bus.err_tag       = err_tag_reg;

endmodule

// File: tb/tb_wb_reorder_buffer.sv
// Directed self-checking bench for wb_reorder_buffer.
module tb_wb_reorder_buffer;

  localparam int IL = 20;
  localparam int OI = 3;
  localparam int DL = 512;
  localparam int TW = 3;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  wb_reorder_buffer_if #(.info_length(IL), .order_id(OI), .data_length(DL), .tag_width(TW)) bus ();

  wb_reorder_buffer #(.info_length(IL), .order_id(OI), .data_length(DL), .tag_width(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DL-1:0] pat(input logic [IL-1:0] info);
    return {16{12'hDA5, info}};
  endfunction

  task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req     = 1'b0;
    bus.lkp_vld       = 1'b0;
    bus.lkp_tag       = '0;
    bus.lkp_info      = '0;
    bus.lkp_id        = '0;
    bus.lkp_so        = 1'b0;
    bus.lkp_data      = '0;
    bus.output_busy_0 = 1'b0;
  endtask

  // Result for tag t carries id=t and so set only for tag 0.
  task automatic result(input logic [TW-1:0] tag, input logic [IL-1:0] info);
    bus.lkp_vld  = 1'b1;
    bus.lkp_tag  = tag;
    bus.lkp_info = info;
    bus.lkp_id   = tag;
    bus.lkp_so   = (tag == '0);
    bus.lkp_data = pat(info);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // Reset state, first allocation
    step();
    bus.alloc_req = 1'b1;
    #1;
    chk("rst_gnt", bus.alloc_gnt, 0);
    chk("rst_valid", bus.reg0_wb_valid, 0);
    bus.alloc_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rel_valid", bus.reg0_wb_valid, 0);
    chk("rel_tag", bus.alloc_tag, 0);
    chk("rel_cnt", bus.rob_cnt, 0);
    chk("rel_err", bus.err_tag, 0);
    bus.alloc_req = 1'b1;
    #1;
    chk("a0_gnt", bus.alloc_gnt, 1);
    chk("a0_tag", bus.alloc_tag, 0);
    step();
    bus.alloc_req = 1'b0;
    #1;
    chk("a0_cnt", bus.rob_cnt, 1);
    chk("a0_next_tag", bus.alloc_tag, 1);

    // Out-of-order return 2,0,1 -> in-order pushes 0,1,2
    bus.alloc_req = 1'b1;
    step();
    step();
    bus.alloc_req = 1'b0;
    #1;
    chk("ooo_cnt", bus.rob_cnt, 3);
    result(3'd2, 20'h00002);
    step();
    result(3'd0, 20'h00000);
    #1;
    chk("ooo_wait", bus.reg0_wb_valid, 0);
    step();
    result(3'd1, 20'h00001);
    #1;
    chk("push0_valid", bus.reg0_wb_valid, 1);
    chk("push0_info", bus.reg0_wb_info, 20'h00000);
    chk("push0_id", bus.reg0_wb_id, 0);
    chk("push0_so", bus.reg0_wb_so, 1);
    chk("push0_data", bus.reg_data_o, pat(20'h00000));
    step();
    bus.lkp_vld = 1'b0;
    #1;
    chk("push1_valid", bus.reg0_wb_valid, 1);
    chk("push1_info", bus.reg0_wb_info, 20'h00001);
    chk("push1_id", bus.reg0_wb_id, 1);
    chk("push1_so", bus.reg0_wb_so, 0);
    step();
    #1;
    chk("push2_valid", bus.reg0_wb_valid, 1);
    chk("push2_info", bus.reg0_wb_info, 20'h00002);
    chk("push2_data", bus.reg_data_o, pat(20'h00002));
    step();
    #1;
    chk("drain_valid", bus.reg0_wb_valid, 0);
    chk("drain_cnt", bus.rob_cnt, 0);

    // Full buffer, no retire bypass, tag wrap
    do_reset();
    bus.alloc_req = 1'b1;
    repeat (8) step();
    #1;
    chk("full_cnt", bus.rob_cnt, 8);
    chk("full_gnt", bus.alloc_gnt, 0);
    result(3'd0, 20'h00100);
    step();
    bus.lkp_vld = 1'b0;
    #1;
    chk("full_retire", bus.reg0_wb_valid, 1);
    chk("nobypass_gnt", bus.alloc_gnt, 0);
    step();
    #1;
    chk("wrap_gnt", bus.alloc_gnt, 1);
    chk("wrap_tag", bus.alloc_tag, 0);
    chk("wrap_cnt", bus.rob_cnt, 7);
    step();
    bus.alloc_req = 1'b0;
    #1;
    chk("refill_cnt", bus.rob_cnt, 8);

    // Back-pressure on a DONE head slot (tag 1)
    bus.output_busy_0 = 1'b1;
    result(3'd1, 20'h00111);
    step();
    bus.lkp_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_valid", bus.reg0_wb_valid, 0);
      chk("busy_cnt", bus.rob_cnt, 8);
      step();
    end
    bus.output_busy_0 = 1'b0;
    #1;
    chk("unbusy_valid", bus.reg0_wb_valid, 1);
    chk("unbusy_info", bus.reg0_wb_info, 20'h00111);
    chk("unbusy_id", bus.reg0_wb_id, 1);
    chk("unbusy_so", bus.reg0_wb_so, 0);
    chk("unbusy_data", bus.reg_data_o, pat(20'h00111));
    step();
    #1;
    chk("unbusy_cnt", bus.rob_cnt, 7);

    // Protocol errors: result to FREE tag 5, then duplicate to DONE tag 0
    do_reset();
    bus.alloc_req = 1'b1;
    repeat (4) step();
    bus.alloc_req = 1'b0;
    bus.output_busy_0 = 1'b1;
    result(3'd0, 20'h000AA);
    step();
    result(3'd5, 20'h00055);
    #1;
    chk("err_pre", bus.err_tag, 0);
    chk("err_free_valid", bus.reg0_wb_valid, 0);
    step();
    result(3'd0, 20'h000BB);
    #1;
    chk("err_free", bus.err_tag, 1);
    step();
    bus.lkp_vld = 1'b0;
    bus.output_busy_0 = 1'b0;
    #1;
    chk("err_sticky", bus.err_tag, 1);
    chk("err_cnt", bus.rob_cnt, 4);
    chk("orig_valid", bus.reg0_wb_valid, 1);
    chk("orig_info", bus.reg0_wb_info, 20'h000AA);
    chk("orig_data", bus.reg_data_o, pat(20'h000AA));
    step();
    #1;
    chk("err_after_valid", bus.reg0_wb_valid, 0);
    chk("err_after_cnt", bus.rob_cnt, 3);

    // Asynchronous reset mid-cycle with 4 slots occupied
    bus.output_busy_0 = 1'b1;
    result(3'd1, 20'h00321);
    bus.alloc_req = 1'b1;
    step();
    bus.lkp_vld = 1'b0;
    bus.alloc_req = 1'b0;
    bus.output_busy_0 = 1'b0;
    #1;
    chk("pre_rst_valid", bus.reg0_wb_valid, 1);
    chk("pre_rst_cnt", bus.rob_cnt, 4);
    #2;
    rst = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    chk("arst_valid", bus.reg0_wb_valid, 0);
    chk("arst_cnt", bus.rob_cnt, 0);
    chk("arst_err", bus.err_tag, 0);
    chk("arst_tag", bus.alloc_tag, 0);
    chk("arst_gnt", bus.alloc_gnt, 0);
    step();
    bus.alloc_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_tag", bus.alloc_tag, 0);
    chk("post_valid", bus.reg0_wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_valid", bus.reg0_wb_valid, 0);
    end
    bus.alloc_req = 1'b1;
    #1;
    chk("post_gnt", bus.alloc_gnt, 1);
    chk("post_gnt_tag", bus.alloc_tag, 0);
    step();
    bus.alloc_req = 1'b0;
    #1;
    chk("post_cnt", bus.rob_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_reorder_buffer.md
Name: wb_reorder_buffer

Overview:
Writeback-stage reorder buffer that sits directly upstream of the output interface FIFO. At ingress, each packet receives a sequence tag in arrival order. Lookup results return carrying that tag, possibly out of order. The block stores each result and pushes results into the output interface strictly in tag-allocation order, honouring the interface's busy back-pressure.

Parameters:
info_length, 20, lookup sideband width
order_id, 3, ordering-id width
data_length, 512, payload width
tag_width, 3, tag width; ROB depth DEPTH = 2^tag_width = 8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
alloc_req  in  1  ingress requests a tag
alloc_gnt  out  1  tag granted this cycle
alloc_tag  out  tag_width  tag granted (valid when alloc_gnt)
lkp_vld  in  1  lookup result valid
lkp_tag  in  tag_width  tag of the result
lkp_info  in  info_length  lookup result
lkp_id  in  order_id  ordering id
lkp_so  in  1  start-of-order flag
lkp_data  in  data_length  payload
output_busy_0  in  1  output FIFO full
reg0_wb_valid  out  1  push to output FIFO
reg0_wb_info  out  info_length  pushed info
reg0_wb_id  out  order_id  pushed id
reg0_wb_so  out  1  pushed so
reg_data_o  out  data_length  pushed payload
rob_cnt  out  tag_width+1  occupied slots
err_tag  out  1  sticky protocol error

Behaviour:
- Pointers: alloc_ptr and head_ptr are tag_width+1 bits each, including a wrap bit. rob_cnt = alloc_ptr - head_ptr, computed modulo 2^(tag_width+1).
- Per-slot state encoding: FREE=0, PEND=1, DONE=2.
- Allocation:
  - alloc_gnt = alloc_req && rob_cnt < DEPTH (combinational).
  - alloc_tag = alloc_ptr[tag_width-1:0] (combinational).
  - On grant, the slot becomes PEND and alloc_ptr increments. Tags wrap 7 -> 0.
  - Full check uses the registered count only. There is no same-cycle bypass from retire: if full and retiring in the same cycle, alloc_gnt = 0.
- Result capture:
  - lkp_vld to a PEND slot: write info/id/so/data into the slot storage and set the slot to DONE on the next edge.
  - lkp_vld to a FREE or DONE slot: drop the result, leave storage unchanged, and set err_tag to 1. err_tag stays set until reset.
- Retire (combinational toward the FIFO, because the FIFO samples full in the same cycle):
  - reg0_wb_valid = (slot[head]==DONE) && !output_busy_0.
  - reg0_wb_info, reg0_wb_id, reg0_wb_so and reg_data_o are driven from the head slot's storage. When valid=0 they still show head storage; the consumer ignores them.
  - On valid, the head slot becomes FREE and head_ptr increments. The FIFO accepts the push that same cycle.
  - At most one retire per cycle.
- Latency: a result arriving at cycle t for the head slot produces reg0_wb_valid at t+1 when not busy. A result cannot retire in its own arrival cycle.
- Simultaneous events:
  - Allocation, result capture and retire may all occur in one cycle on different slots.
  - A result landing on the head slot in the same cycle as busy simply waits.
  - output_busy_0 held high stalls retire indefinitely. Allocation and capture continue until the buffer is full.
- Reset (rst=0, asynchronous, at any time, including mid-operation):
  - All slots become FREE, both pointers 0, err_tag 0.
  - Therefore reg0_wb_valid=0, alloc_gnt=0 (regardless of alloc_req), rob_cnt=0, alloc_tag=0.
  - Payload storage is not reset; its outputs are don't-care while valid=0.

Decomposition:
- Shared package:
  - Slot-state encoding (FREE/PEND/DONE).
  - DEPTH derivation.
  - Field offsets for the stored word {info, id, so, data}, laid out info at the MSB, then id, then so, then payload at the LSB.
- One sub-module: wb_rob_mem.
  - DEPTH x (info_length+order_id+1+data_length) register array.
  - One synchronous write port (tag, data, we).
  - One combinational read port (head index).
  - No reset.
- Control (pointers, slot states, error flag) stays in wb_reorder_buffer.

Test Plan:
- Reset release -> reg0_wb_valid=0, alloc_tag=0, rob_cnt=0, err_tag=0. alloc_req=1 for one cycle -> alloc_gnt=1, alloc_tag=0, rob_cnt=1 next cycle.
- Allocate tags 0,1,2; return results in order 2,0,1 with info 0x00002, 0x00000, 0x00001 -> pushes occur in order info 0x00000, 0x00001, 0x00002. The first push comes one cycle after tag 0's result; the next two come on consecutive cycles.
- Eight allocations -> rob_cnt=8 and a 9th alloc_req gets alloc_gnt=0. Retire tag 0 -> the grant comes on the next cycle with alloc_tag=0 (wrap), and rob_cnt returns to 8.
- Head slot DONE with output_busy_0=1 for 5 cycles -> reg0_wb_valid=0 and head unchanged throughout. Drop busy -> reg0_wb_valid=1 in that same cycle with the correct fields.
- lkp_vld to FREE tag 5, then a second result to an already-DONE tag 0 -> err_tag=1 after the first event and stays 1. Neither event produces a push, and tag 0's original data is what is pushed.
- Assert rst low mid-cycle with 4 slots PEND/DONE -> outputs clear immediately without waiting for a clock edge. After release, tags restart at 0 and no stale packet is pushed.
